// File: rtl/ram16k.sv
// ram16k: 16384 x WIDTH data memory built from four 4096-word banks.
// Synchronous write on the rising clock edge, combinational read, and an
// asynchronous active-low reset that makes every word read as zero.
//
// Ports:
//   clock    - system clock, all state changes on the rising edge
//   reset_n  - asynchronous active-low clear of the whole memory
//   in       - write data
//   address  - word address for read and write; [13:12] bank, [11:0] offset
//   load     - write enable, active-high
//   out      - contents of the word at address (zero latency)

// One 2^AW-word bank. Each word has a valid bit that is cleared
// asynchronously on reset; an invalid word reads as zero. The data array
// itself needs no reset, so it maps onto a plain RAM array.
module ram16k_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;

  // Data array: written only when the bank is selected and not held in reset.
  always_ff @(posedge clock) begin
    if (reset_n && we) begin
      mem[addr] <= din;
    end
  end

  // Valid bits: the only state that needs the asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else if (we) begin
      vld[addr] <= 1'b1;
    end
  end

  // Combinational read; unwritten or cleared words read zero.
  assign dout = vld[addr] ? mem[addr] : '0;

endmodule

module ram16k #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  output logic [WIDTH-1:0]  out
);

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NBANK   = 1 << SEL_W;
  localparam int unsigned BANK_AW = ADDR_W - SEL_W;

  logic [SEL_W-1:0]   sel;
  logic [BANK_AW-1:0] offset;
  logic [WIDTH-1:0]   bank_rd [NBANK];

  assign sel    = address[ADDR_W-1 -: SEL_W];
  assign offset = address[BANK_AW-1:0];

  // Exactly one bank sees the write enable; all banks decode the same offset.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ram16k_bank #(
      .WIDTH (WIDTH),
      .AW    (BANK_AW)
    ) u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (load && (sel == SEL_W'(b))),
      .addr    (offset),
      .din     (in),
      .dout    (bank_rd[b])
    );
  end

  // Read mux by bank select.
  assign out = bank_rd[sel];

endmodule

// File: tb/tb_ram16k.sv
// Self-checking bench for ram16k: directed tables, hand sequences for the
// reset/timing corners, and random traffic against an associative-array model.
module tb_ram16k;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic [13:0] address;
  logic        load;
  logic [15:0] out;

  int n_cmp;
  int n_fail;

  // Reference memory: absent keys are words that read as zero.
  logic [15:0] model [int];

  typedef struct {
    logic [13:0] addr;
    logic [15:0] din;
    logic        ld;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[$];

  int pool [8] = '{0, 1, 4095, 4096, 8191, 8192, 12288, 16383};

  ram16k dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .address (address),
    .load    (load),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] mref(input int a);
    return model.exists(a) ? model[a] : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] exp);
    n_cmp++;
    if (out !== exp) begin
      n_fail++;
      $display("FAIL %s: addr=%0d got=%h expected=%h", name, address, out, exp);
    end
  endtask

  // Combinational read: change address, settle, compare against a constant.
  task automatic rd(input string name, input int a, input logic [15:0] exp);
    address = 14'(a);
    #1;
    check(name, exp);
  endtask

  // One-edge write; inputs are driven 1 time unit after a rising edge.
  task automatic wr(input int a, input logic [15:0] d);
    address = 14'(a);
    in      = d;
    load    = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    if (reset_n) model[a] = d;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    in      = '0;
    address = '0;
    load    = 1'b0;

    // Reset then read
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold", 16'h0000);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    rd("rst_sweep", 0, 16'h0000);
    for (int i = 0; i < 14; i++) rd("rst_sweep", 1 << i, 16'h0000);
    rd("rst_sweep", 16383, 16'h0000);

    // Single write then walking-address read
    wr(2048, 16'd15);
    rd("walk", 0, 16'h0000);
    for (int i = 0; i <= 10; i++) rd("walk", 1 << i, 16'h0000);
    rd("walk_hit", 2048, 16'd15);
    rd("walk_alias", 4096, 16'h0000);
    rd("walk_alias", 8192, 16'h0000);
    rd("walk_alias", 16383, 16'h0000);

    // Load-gated write
    address = 14'd100;
    in      = 16'hBEEF;
    load    = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("gate_off", 16'h0000);
    end
    load = 1'b1;
    #1;
    check("gate_pre_edge", 16'h0000);
    @(posedge clock);
    #1;
    load = 1'b0;
    model[100] = 16'hBEEF;
    check("gate_post_edge", 16'hBEEF);

    // Bank boundaries (table-driven)
    vt.push_back('{14'd4095,  16'h1111, 1'b1, 16'h1111});
    vt.push_back('{14'd4096,  16'h2222, 1'b1, 16'h2222});
    vt.push_back('{14'd12287, 16'h3333, 1'b1, 16'h3333});
    vt.push_back('{14'd12288, 16'h4444, 1'b1, 16'h4444});
    vt.push_back('{14'd16383, 16'hFFFF, 1'b1, 16'hFFFF});
    vt.push_back('{14'd0,     16'hA5A5, 1'b1, 16'hA5A5});
    vt.push_back('{14'd4095,  16'h0BAD, 1'b0, 16'h1111});
    vt.push_back('{14'd4096,  16'h0BAD, 1'b0, 16'h2222});
    vt.push_back('{14'd12287, 16'h0BAD, 1'b0, 16'h3333});
    vt.push_back('{14'd12288, 16'h0BAD, 1'b0, 16'h4444});
    vt.push_back('{14'd16383, 16'h0BAD, 1'b0, 16'hFFFF});
    vt.push_back('{14'd0,     16'h0BAD, 1'b0, 16'hA5A5});
    vt.push_back('{14'd4094,  16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd4097,  16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd8191,  16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd8192,  16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd12286, 16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd12289, 16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd16382, 16'h0BAD, 1'b0, 16'h0000});
    vt.push_back('{14'd1,     16'h0BAD, 1'b0, 16'h0000});
    foreach (vt[i]) begin
      address = vt[i].addr;
      in      = vt[i].din;
      load    = vt[i].ld;
      @(posedge clock);
      #1;
      load = 1'b0;
      if (vt[i].ld) model[int'(vt[i].addr)] = vt[i].din;
      check("bank_tbl", vt[i].exp);
    end

    // Overwrite plus combinational address toggling
    wr(2048, 16'd5);
    wr(2048, 16'd7);
    check("overwrite", 16'd7);
    rd("toggle", 2047, 16'h0000);
    rd("toggle", 2048, 16'd7);
    rd("toggle", 2047, 16'h0000);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int a;
      logic [15:0] d;
      a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)]
                                      : int'($urandom_range(0, 16383));
      if ($urandom_range(0, 1) == 0) begin
        d = 16'($urandom);
        address = 14'(a);
        in      = d;
        load    = 1'b1;
        #1;
        check("rnd_pre_edge", mref(a));
        @(posedge clock);
        #1;
        load = 1'b0;
        model[a] = d;
        check("rnd_post_edge", d);
      end else begin
        rd("rnd_read", a, mref(a));
      end
    end

    // Asynchronous reset between edges
    wr(4096, 16'h2222);
    wr(300, 16'h0300);
    address = 14'd4096;
    #1;
    check("pre_async_rst", 16'h2222);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", 16'h0000);
    model.delete();
    address = 14'd500;
    in      = 16'h1234;
    load    = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    check("write_in_rst", 16'h0000);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    rd("post_rst", 500, 16'h0000);
    rd("post_rst", 300, 16'h0000);
    rd("post_rst", 2048, 16'h0000);
    rd("post_rst", 100, 16'h0000);
    rd("post_rst", 4095, 16'h0000);
    rd("post_rst", 12288, 16'h0000);
    for (int i = 0; i < 8; i++) rd("post_rst_pool", pool[i], 16'h0000);

    // Memory works again after reset release
    wr(16383, 16'h5A5A);
    check("post_rst_write", 16'h5A5A);
    rd("post_rst_neigh", 16382, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
